// File: rtl/des_pkg.sv
// Shared DES controller types: FSM states, bus widths, core request payload.
// Build option DES_CBC_CHAIN_EN (used by des_cbc_ctrl) selects CBC over ECB chaining.
package des_pkg;

  localparam int unsigned DES_BLOCK_W = 64;
  localparam int unsigned DES_KEY_W   = 64;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } des_state_e;

  // Registered operands presented to the combinational DES core.
  typedef struct packed {
    logic [DES_BLOCK_W-1:0] block;
    logic [DES_KEY_W-1:0]   key;
  } des_core_req_t;

  function automatic logic [DES_BLOCK_W-1:0] cbc_mix(
    input logic [DES_BLOCK_W-1:0] data,
    input logic [DES_BLOCK_W-1:0] chain
  );
    return data ^ chain;
  endfunction

endpackage

// File: rtl/des_cbc_ctrl.sv
// Block-chaining controller feeding an external combinational DES core.
// DES_CBC_CHAIN_EN defined: CBC (IV / previous ciphertext XOR); undefined: ECB.
module des_cbc_ctrl
  import des_pkg::*;
#(
  parameter int unsigned CORE_WAIT = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [DES_KEY_W-1:0]   KEY,
  input  logic [DES_BLOCK_W-1:0] IV,
  input  logic                   IV_LOAD,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [DES_BLOCK_W-1:0] IN_DATA,
  output logic [DES_BLOCK_W-1:0] CORE_PT,
  output logic [DES_KEY_W-1:0]   CORE_KEY,
  input  logic [DES_BLOCK_W-1:0] CORE_CT,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DES_BLOCK_W-1:0] OUT_DATA
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_WAIT - 1);

  des_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  des_core_req_t          core_q, core_d;
  logic [DES_BLOCK_W-1:0] out_data_d;
  logic                   out_valid_d;
  logic [DES_BLOCK_W-1:0] chain_mix;
  logic                   iv_take;
  logic                   accept;
  logic                   capture;

  assign accept   = IN_VALID && IN_READY;
  assign capture  = (state_q == WAIT) && (cnt_q == '0);
  assign IN_READY = (state_q == IDLE) && !iv_take;
  assign CORE_PT  = core_q.block;
  assign CORE_KEY = core_q.key;

`ifdef DES_CBC_CHAIN_EN
  logic [DES_BLOCK_W-1:0] chain_q, chain_d;

  assign iv_take   = (state_q == IDLE) && IV_LOAD;
  assign chain_mix = chain_q;

  // Chain holds the IV or the most recent ciphertext until reloaded.
  always_comb begin
    chain_d = chain_q;
    if (iv_take) begin
      chain_d = IV;
    end else if (capture) begin
      chain_d = CORE_CT;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end
`else
  logic unused_ecb;

  assign iv_take    = 1'b0;
  assign chain_mix  = '0;
  assign unused_ecb = ^{IV, IV_LOAD};
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_d      = core_q;
    out_data_d  = OUT_DATA;
    out_valid_d = OUT_VALID;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          core_d.block = cbc_mix(IN_DATA, chain_mix);
          core_d.key   = KEY;
          cnt_d        = CNT_LOAD;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (capture) begin
          out_data_d  = CORE_CT;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      core_q    <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      core_q    <= core_d;
      OUT_DATA  <= out_data_d;
      OUT_VALID <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Directed bench for des_cbc_ctrl with a stand-in DES core (known vector, else PT ^ KEY).
// Expectations follow DES_CBC_CHAIN_EN when it is defined.
module tb_des_cbc_ctrl;
  import des_pkg::*;

  localparam int unsigned CORE_WAIT = 2;
  localparam logic [63:0] K0 = 64'h8FFB3DD99EEA2CC8;
  localparam logic [63:0] P0 = 64'hF7B3D591E6A2C480;
  localparam logic [63:0] P1 = 64'h725BC6C5E9A87085;
  localparam logic [63:0] C0 = 64'h85E813540F0AB405;
`ifdef DES_CBC_CHAIN_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key = '0;
  logic [63:0] iv = '0;
  logic        iv_load = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [63:0] core_pt;
  logic [63:0] core_key;
  logic [63:0] core_ct;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in for the combinational DES core.
  always_comb core_ct = (core_pt == P0 && core_key == K0) ? C0 : (core_pt ^ core_key);

  des_cbc_ctrl #(.CORE_WAIT(CORE_WAIT)) dut (
    .CLK(clk), .RST_N(rst_n), .KEY(key), .IV(iv), .IV_LOAD(iv_load),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .CORE_PT(core_pt), .CORE_KEY(core_key), .CORE_CT(core_ct),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data)
  );

  typedef struct {
    logic        iv_load;
    logic [63:0] iv;
    logic [63:0] key;
    logic [63:0] data;
    logic [63:0] exp_pt;
    logic [63:0] exp_ct;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_block(input string tag, input logic [63:0] data,
                              input logic [63:0] k, input logic [63:0] exp_pt);
    in_valid = 1'b1;
    in_data  = data;
    key      = k;
    @(negedge clk);
    chk({tag, " in_ready_pre"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, " core_pt"}, core_pt, exp_pt);
    chk({tag, " core_key"}, core_key, k);
    chk({tag, " out_valid_early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic finish_block(input string tag, input logic [63:0] exp_ct, input int hold);
    for (int k = 1; k < CORE_WAIT; k++) begin
      tick();
      chk({tag, " out_valid_wait"}, 64'(out_valid), 64'd0);
    end
    tick();
    chk({tag, " out_valid_rise"}, 64'(out_valid), 64'd1);
    chk({tag, " out_data"}, out_data, exp_ct);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold_data"}, out_data, exp_ct);
      chk({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
`ifdef DES_CBC_CHAIN_EN
    vecs[0] = '{1'b1, 64'h0, K0, P0, P0, C0};
    vecs[1] = '{1'b0, 64'h0, K0, P1, P0, C0};
    vecs[2] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0123456789ABCDEF,
                64'hFEDCBA9876543210, 64'hFEDCBA9876543210};
    vecs[3] = '{1'b0, 64'h0, 64'h00000000FFFFFFFF, 64'hFEDCBA9876543210,
                64'h0, 64'h00000000FFFFFFFF};
`else
    vecs[0] = '{1'b1, 64'h0, K0, P0, P0, C0};
    vecs[1] = '{1'b0, 64'h0, K0, P0, P0, C0};
    vecs[2] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0123456789ABCDEF,
                64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecs[3] = '{1'b0, 64'h0, 64'h00000000FFFFFFFF, 64'hFEDCBA9876543210,
                64'hFEDCBA9876543210, 64'hFEDCBA9889ABCDEF};
`endif

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", out_data, 64'd0);
    chk("rst core_pt", core_pt, 64'd0);
    chk("rst core_key", core_key, 64'd0);

    // Table-driven blocks
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].iv_load) begin
        iv_load = 1'b1;
        iv      = vecs[i].iv;
        @(negedge clk);
        chk($sformatf("vec%0d iv_load_ready", i), 64'(in_ready), CBC ? 64'd0 : 64'd1);
        tick();
        iv_load = 1'b0;
      end
      accept_block($sformatf("vec%0d", i), vecs[i].data, vecs[i].key, vecs[i].exp_pt);
      finish_block($sformatf("vec%0d", i), vecs[i].exp_ct, i % 2);
    end

    // Back-pressure: 10 cycles of OUT_READY low with a waiting input block
    accept_block("bp", 64'h1111111111111111, 64'h0,
                 CBC ? 64'h11111111EEEEEEEE : 64'h1111111111111111);
    in_valid = 1'b1;
    in_data  = 64'h2222222222222222;
    finish_block("bp", CBC ? 64'h11111111EEEEEEEE : 64'h1111111111111111, 10);
    accept_block("bp_next", 64'h2222222222222222, 64'h0,
                 CBC ? 64'h33333333CCCCCCCC : 64'h2222222222222222);
    finish_block("bp_next", CBC ? 64'h33333333CCCCCCCC : 64'h2222222222222222, 0);

    // IV_LOAD and IN_VALID in the same IDLE cycle
    iv_load  = 1'b1;
    iv       = 64'hFFFF0000FFFF0000;
    in_valid = 1'b1;
    in_data  = 64'h0123456789ABCDEF;
    key      = 64'h0;
    @(negedge clk);
    chk("ivv in_ready", 64'(in_ready), CBC ? 64'd0 : 64'd1);
    tick();
    iv_load = 1'b0;
`ifdef DES_CBC_CHAIN_EN
    chk("ivv not_accepted", core_pt, 64'h33333333CCCCCCCC);
    accept_block("ivv", 64'h0123456789ABCDEF, 64'h0, 64'hFEDC45677654CDEF);
    finish_block("ivv", 64'hFEDC45677654CDEF, 0);
`else
    in_valid = 1'b0;
    chk("ivv core_pt", core_pt, 64'h0123456789ABCDEF);
    finish_block("ivv", 64'h0123456789ABCDEF, 0);
`endif

    // Reset during WAIT aborts the block and clears the chain
    accept_block("rw", 64'h0123456789ABCDEF, 64'h0,
                 CBC ? 64'hFFFF0000FFFF0000 : 64'h0123456789ABCDEF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw out_valid", 64'(out_valid), 64'd0);
    chk("rw out_data", out_data, 64'd0);
    chk("rw core_pt", core_pt, 64'd0);
    chk("rw in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < CORE_WAIT + 1; k++) begin
      tick();
      chk("rw no_output", 64'(out_valid), 64'd0);
    end
    accept_block("rw_after", 64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF);
    finish_block("rw_after", 64'h0123456789ABCDEF, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
